phase_seq: RTL and testbench

PHASE_SEQ -- requirements
Module: phase_seq

---
 rtl/phase_seq_if.sv | 28 ++
 rtl/phase_seq.sv | 139 +++++++++++++
 tb/tb_phase_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_seq_if.sv
// Control/status bundle of the phase sequencer: run controls in, phase and decodes out.
interface phase_seq_if #(
    parameter int NPH  = 8,
    parameter int DIVW = 2
);
    logic            en;
    logic [DIVW-1:0] div;
    logic            div_ld;
    logic            wait_req;
    logic [NPH-1:0]  phase;
    logic            ph_stb;
    logic            cyc_start;
    logic            addrsel;
    logic            latch;
    logic            cycsel;
    logic [7:0]      cyc_cnt;
    logic [DIVW-1:0] div_act;

    modport master (
        output en, div, div_ld, wait_req,
        input  phase, ph_stb, cyc_start, addrsel, latch, cycsel, cyc_cnt, div_act
    );

    modport slave (
        input  en, div, div_ld, wait_req,
        output phase, ph_stb, cyc_start, addrsel, latch, cycsel, cyc_cnt, div_act
    );
endinterface

// File: rtl/phase_seq.sv
// One-hot bus-cycle phase sequencer with prescaler, registered phase decodes and cycle counter.
// Optional wait_req cycle stretching is built when PHASE_SEQ_STRETCH_EN is defined.
module phase_seq #(
    parameter int NPH        = 8,
    parameter int DIVW       = 2,
    parameter int ADDRSEL_PH = 4,
    parameter int LATCH_PH   = 5,
    parameter int WAIT_PH    = 5
) (
    input  logic       clk,
    input  logic       res,
    phase_seq_if.slave bus
);

    // state   | meaning
    // IDLE    | parked in phase 0, prescaler cleared, waiting for en
    // RUN     | prescaler counting, phase advances on every tick
    // STRETCH | held in WAIT_PH while wait_req stays high
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STRETCH = 2'd2
    } state_t;

    localparam logic [NPH-1:0] PH0        = {{(NPH-1){1'b0}}, 1'b1};
    localparam logic [NPH-1:0] ADDR_MASK  = {NPH{1'b1}} << ADDRSEL_PH;
    localparam logic [NPH-1:0] CYC_MASK   = {NPH{1'b1}} << (NPH / 2);
    localparam logic [NPH-1:0] LATCH_MASK = PH0 << LATCH_PH;

    state_t          state;
    logic [NPH-1:0]  phase;
    logic [DIVW-1:0] pc;
    logic [DIVW-1:0] div_act;
    logic [DIVW-1:0] div_pend;
    logic            pend_vld;
    logic            ph_stb;
    logic            cyc_start;
    logic            addrsel;
    logic            latch;
    logic            cycsel;
    logic [7:0]      cyc_cnt;

    logic            tick;
    logic            wrap;
    logic            wait_live;
    logic            stretch_hit;
    logic [NPH-1:0]  phase_rot;

`ifdef PHASE_SEQ_STRETCH_EN
    assign wait_live = bus.wait_req;
`else
    logic unused_wait;
    assign unused_wait = bus.wait_req;
    assign wait_live   = 1'b0;
`endif

    assign tick        = (state == RUN) && (pc == div_act);
    assign wrap        = phase[NPH-1];
    assign phase_rot   = {phase[NPH-2:0], phase[NPH-1]};
    assign stretch_hit = tick && phase[WAIT_PH] && wait_live;

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            phase     <= PH0;
            pc        <= '0;
            ph_stb    <= 1'b0;
            cyc_start <= 1'b0;
            addrsel   <= |(PH0 & ADDR_MASK);
            latch     <= |(PH0 & LATCH_MASK);
            cycsel    <= |(PH0 & CYC_MASK);
            cyc_cnt   <= 8'd0;
            div_act   <= bus.div;
            div_pend  <= '0;
            pend_vld  <= 1'b0;
        end else begin
            ph_stb    <= 1'b0;
            cyc_start <= 1'b0;
            case (state)
                IDLE: begin
                    pc <= '0;
                    if (bus.div_ld) div_act <= bus.div;
                    if (bus.en) state <= RUN;
                end
                RUN: begin
                    if (bus.div_ld) begin
                        div_pend <= bus.div;
                        pend_vld <= 1'b1;
                    end
                    if (stretch_hit) begin
                        state <= STRETCH;
                        pc    <= '0;
                    end else if (tick) begin
                        pc      <= '0;
                        phase   <= phase_rot;
                        ph_stb  <= 1'b1;
                        addrsel <= |(phase_rot & ADDR_MASK);
                        latch   <= |(phase_rot & LATCH_MASK);
                        cycsel  <= |(phase_rot & CYC_MASK);
                        if (wrap) begin
                            cyc_start <= 1'b1;
                            cyc_cnt   <= cyc_cnt + 8'd1;
                            pend_vld  <= 1'b0;
                            // a div_ld on the wrap tick itself governs the cycle starting now
                            if (bus.div_ld)
                                div_act <= bus.div;
                            else if (pend_vld)
                                div_act <= div_pend;
                            if (!bus.en) state <= IDLE;
                        end
                    end else begin
                        pc <= pc + {{(DIVW-1){1'b0}}, 1'b1};
                    end
                end
                STRETCH: begin
                    if (bus.div_ld) begin
                        div_pend <= bus.div;
                        pend_vld <= 1'b1;
                    end
                    if (!wait_live) begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.phase     = phase;
    assign bus.ph_stb    = ph_stb;
    assign bus.cyc_start = cyc_start;
    assign bus.addrsel   = addrsel;
    assign bus.latch     = latch;
    assign bus.cycsel    = cycsel;
    assign bus.cyc_cnt   = cyc_cnt;
    assign bus.div_act   = div_act;

endmodule

// File: tb/tb_phase_seq.sv
// Bench for phase_seq: directed timing scenarios plus randomized run against a phase-level reference model.
module tb_phase_seq;

    localparam int NPH        = 8;
    localparam int DIVW       = 2;
    localparam int ADDRSEL_PH = 4;
    localparam int LATCH_PH   = 5;
    localparam int WAIT_PH    = 5;
`ifdef PHASE_SEQ_STRETCH_EN
    localparam bit M_STRETCH = 1'b1;
`else
    localparam bit M_STRETCH = 1'b0;
`endif

    logic clk;
    logic res;

    phase_seq_if #(.NPH(NPH), .DIVW(DIVW)) bus ();

    phase_seq #(
        .NPH(NPH), .DIVW(DIVW), .ADDRSEL_PH(ADDRSEL_PH),
        .LATCH_PH(LATCH_PH), .WAIT_PH(WAIT_PH)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: integer phase index, clocks remaining until the next advance,
    // divider in use and an optional pending divider (-1 = none).
    int m_mode;   // 0 parked, 1 running, 2 held
    int m_idx;
    int m_left;
    int m_div;
    int m_pend;
    int m_cyc;
    bit m_stb;
    bit m_cs;

    task automatic model(input bit r, input bit en_i, input bit ld, input bit w, input int d);
        m_stb = 1'b0;
        m_cs  = 1'b0;
        if (r) begin
            m_mode = 0; m_idx = 0; m_cyc = 0; m_div = d; m_pend = -1; m_left = 0;
            return;
        end
        case (m_mode)
            0: begin
                if (ld) m_div = d;
                if (en_i) begin
                    m_mode = 1;
                    m_left = m_div + 1;
                end
            end
            1: begin
                if (ld) m_pend = d;
                if (m_left > 1) begin
                    m_left--;
                end else if (M_STRETCH && w && m_idx == WAIT_PH) begin
                    m_mode = 2;
                end else begin
                    m_stb = 1'b1;
                    m_idx = (m_idx + 1) % NPH;
                    if (m_idx == 0) begin
                        m_cs  = 1'b1;
                        m_cyc = (m_cyc + 1) % 256;
                        if (m_pend >= 0) m_div = m_pend;
                        m_pend = -1;
                        if (!en_i) m_mode = 0;
                    end
                    m_left = m_div + 1;
                end
            end
            default: begin
                if (ld) m_pend = d;
                if (!w) begin
                    m_mode = 1;
                    m_left = m_div + 1;
                end
            end
        endcase
    endtask

    task automatic step();
        bit i_res, i_en, i_ld, i_wait;
        int i_div;
        i_res  = res;
        i_en   = bus.en;
        i_ld   = bus.div_ld;
        i_wait = bus.wait_req;
        i_div  = int'(bus.div);
        @(posedge clk);
        model(i_res, i_en, i_ld, i_wait, i_div);
        @(negedge clk);
        chk("phase",     32'(bus.phase),     32'd1 << m_idx);
        chk("ph_stb",    32'(bus.ph_stb),    32'(m_stb));
        chk("cyc_start", 32'(bus.cyc_start), 32'(m_cs));
        chk("addrsel",   32'(bus.addrsel),   32'(m_idx >= ADDRSEL_PH));
        chk("latch",     32'(bus.latch),     32'(m_idx == LATCH_PH));
        chk("cycsel",    32'(bus.cycsel),    32'(m_idx >= NPH / 2));
        chk("cyc_cnt",   32'(bus.cyc_cnt),   32'(m_cyc));
        chk("div_act",   32'(bus.div_act),   32'(m_div));
    endtask

    task automatic do_reset(input int d);
        res = 1'b1; bus.en = 1'b0; bus.div_ld = 1'b0; bus.wait_req = 1'b0;
        bus.div = DIVW'(d);
        step();
        step();
        res = 1'b0;
    endtask

    task automatic wait_phase(input int idx, input string tag);
        for (int k = 0; k < 200 && 32'(bus.phase) != (32'd1 << idx); k++) step();
        chk(tag, 32'(bus.phase), 32'd1 << idx);
    endtask

    task automatic wait_cs(input string tag);
        for (int k = 0; k < 200 && !bus.cyc_start; k++) step();
        chk(tag, 32'(bus.cyc_start), 32'd1);
    endtask

    initial begin
        int nst, ncs, len, c0, seen;
        res = 1'b1; bus.en = 1'b0; bus.div = '0; bus.div_ld = 1'b0; bus.wait_req = 1'b0;
        m_mode = 0; m_idx = 0; m_left = 0; m_div = 0; m_pend = -1; m_cyc = 0;

        // Reset state and default-parameter rhythm with div=1
        do_reset(1);
        chk("rst_phase", 32'(bus.phase), 32'd1);
        chk("rst_cnt", 32'(bus.cyc_cnt), 32'd0);
        chk("rst_div_act", 32'(bus.div_act), 32'd1);
        bus.en = 1'b1;
        nst = 0; ncs = 0;
        repeat (49) begin
            step();
            nst += int'(bus.ph_stb);
            ncs += int'(bus.cyc_start);
        end
        chk("d1_stb_count", 32'(nst), 32'd24);
        chk("d1_cs_count", 32'(ncs), 32'd3);
        chk("d1_cyc_cnt", 32'(bus.cyc_cnt), 32'd3);

        // Divider change mid-cycle only applies after the phase-0 wrap
        do_reset(0);
        bus.en = 1'b1;
        wait_phase(2, "d2_reach_ph2");
        bus.div = 2'd3; bus.div_ld = 1'b1;
        step();
        bus.div_ld = 1'b0;
        chk("d2_div_hold", 32'(bus.div_act), 32'd0);
        wait_cs("d2_wrap");
        chk("d2_div_new", 32'(bus.div_act), 32'd3);
        len = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            len++;
            if (bus.ph_stb) break;
        end
        chk("d2_ph0_len", 32'(len), 32'd4);

`ifdef PHASE_SEQ_STRETCH_EN
        // Stretch in WAIT_PH for five sampled wait_req clocks
        do_reset(1);
        bus.en = 1'b1;
        wait_phase(4, "d3_reach_ph4");
        step();
        bus.wait_req = 1'b1;
        step();
        chk("d3_reach_ph5", 32'(bus.phase), 32'd1 << 5);
        len = 0; nst = 0;
        repeat (4) begin
            step();
            len++;
            nst += int'(bus.ph_stb);
        end
        bus.wait_req = 1'b0;
        for (int k = 0; k < 10 && 32'(bus.phase) != 32'd64; k++) begin
            step();
            len++;
            if (32'(bus.phase) != 32'd64) nst += int'(bus.ph_stb);
        end
        chk("d3_ph5_len", 32'(len), 32'd7);
        chk("d3_hold_stb", 32'(nst), 32'd0);
`endif

        // Reset while held (or running) in WAIT_PH
        do_reset(1);
        bus.en = 1'b1;
        wait_phase(WAIT_PH, "d5_reach_wait");
        bus.wait_req = 1'b1;
        repeat (3) step();
        res = 1'b1; bus.en = 1'b0; bus.wait_req = 1'b0;
        step();
        chk("d5_phase", 32'(bus.phase), 32'd1);
        chk("d5_cnt", 32'(bus.cyc_cnt), 32'd0);
        chk("d5_strobes", 32'({bus.ph_stb, bus.cyc_start}), 32'd0);
        res = 1'b0;
        repeat (3) step();
        chk("d5_idle", 32'(bus.phase), 32'd1);

        // en dropped at phase 3: cycle completes then parks
        do_reset(1);
        bus.en = 1'b1;
        wait_phase(3, "d4_reach_ph3");
        bus.en = 1'b0;
        c0 = int'(bus.cyc_cnt);
        seen = 0;
        for (int k = 0; k < 60 && !bus.cyc_start; k++) begin
            step();
            seen |= int'(bus.phase);
        end
        chk("d4_seen_4to7", 32'(seen & 32'hF0), 32'hF0);
        chk("d4_cnt", 32'(bus.cyc_cnt), 32'((c0 + 1) % 256));
        nst = 0;
        repeat (10) begin
            step();
            nst += int'(bus.ph_stb) + int'(bus.cyc_start);
        end
        chk("d4_quiet", 32'(nst), 32'd0);
        chk("d4_parked", 32'(bus.phase), 32'd1);

        // Cycle length NPH*(div+1) with wait_req high where stretching is not built
        do_reset(2);
        bus.en = 1'b1;
        bus.wait_req = !M_STRETCH;
        wait_cs("d6_first_wrap");
        len = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            len++;
            if (bus.cyc_start) break;
        end
        chk("d6_cycle_len", 32'(len), 32'(NPH * 3));
        bus.wait_req = 1'b0;

        // Randomized run against the reference model
        do_reset(int'($urandom_range(0, 3)));
        bus.en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            res = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 59) == 0) bus.en = ~bus.en;
            if (!bus.en && $urandom_range(0, 9) == 0) bus.en = 1'b1;
            bus.div = DIVW'($urandom_range(0, 3));
            bus.div_ld = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) bus.wait_req = ~bus.wait_req;
            step();
        end
        res = 1'b0; bus.div_ld = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
